dm_cache: RTL and testbench

//  Direct-mapped, write-through, no-write-allocate word cache between the core's load/store port and the

---
 rtl/dm_cache_pkg.sv | 21 ++
 rtl/dm_cache_if.sv | 25 ++
 rtl/dm_cache_array.sv | 49 ++++
 rtl/dm_cache.sv | 174 +++++++++++++++++
 tb/tb_dm_cache.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_cache_pkg.sv
// dm_cache_pkg: FSM state encoding and the index-width helper used by dm_cache and dm_cache_array.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package dm_cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_FILL   = 2'd2,
    ST_WRITE  = 2'd3
  } state_e;

  // Ceiling log2, evaluated at elaboration for index and counter widths.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/dm_cache_if.sv
// dm_cache_if: core-side load/store request and response bundle of the cache.
// Latency: n/a (wires only).
// Backpressure: request moves on req_valid & req_ready; the response is a one-cycle pulse with no ready.
// Modports: master = core (drives req_*), slave = cache (drives req_ready, resp_*).
interface dm_cache_if #(
  parameter int BITS = 32
);
  logic            req_valid;
  logic            req_wen;
  logic [BITS-1:0] req_addr;
  logic [BITS-1:0] req_wdata;
  logic            req_ready;
  logic            resp_valid;
  logic [BITS-1:0] resp_rdata;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/dm_cache_array.sv
// dm_cache_array: valid/tag/data storage for the direct-mapped cache, one word per line.
// Latency: combinational read (idx -> hit, data); write takes effect at the next clk edge.
// Backpressure: none; every write strobe is accepted.
// Ports: clk, rst_n (sync active-high, clears valid bits only), rd_idx_i/rd_tag_i -> hit_o/rd_data_o,
//        we_i/wr_idx_i/wr_tag_i/wr_data_i write one whole line and mark it valid.
module dm_cache_array
  import dm_cache_pkg::*;
#(
  parameter int BITS  = 32,
  parameter int LINES = 8,
  parameter int IDX_W = clog2(LINES),
  parameter int TAG_W = BITS - IDX_W - 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx_i,
  input  logic [TAG_W-1:0] rd_tag_i,
  output logic             hit_o,
  output logic [BITS-1:0]  rd_data_o,
  input  logic             we_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic [BITS-1:0]  wr_data_i
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [BITS-1:0]  data_q [LINES];

  assign hit_o     = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
  assign rd_data_o = data_q[rd_idx_i];

  // Only the valid bits are reset; stale tag/data behind a cleared valid bit is harmless.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/dm_cache.sv
// dm_cache: direct-mapped, write-through, no-write-allocate word cache in front of a memory model.
// Latency (accept edge -> resp_valid seen): read hit 2, read miss 2+MISS_LAT, write 3.
// Backpressure: req_ready is high only in IDLE; one request in flight, requester holds while stalled.
// Ports: clk, rst_n (sync, active-high), core (dm_cache_if.slave), mem_wen/mem_a/mem_d to memory,
//        mem_q from memory; hit_cnt/miss_cnt read-hit/miss counters only when DM_CACHE_STATS_EN is defined.
module dm_cache
  import dm_cache_pkg::*;
#(
  parameter int BITS     = 32,
  parameter int LINES    = 8,
  parameter int MISS_LAT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  dm_cache_if.slave       core,
  output logic            mem_wen,
  output logic [BITS-1:0] mem_a,
  output logic [BITS-1:0] mem_d,
  input  logic [BITS-1:0] mem_q
`ifdef DM_CACHE_STATS_EN
  ,
  output logic [31:0]     hit_cnt,
  output logic [31:0]     miss_cnt
`endif
);

  localparam int IDX_W = clog2(LINES);
  localparam int TAG_W = BITS - IDX_W - 2;
  localparam int LAT_W = clog2(MISS_LAT) + 1;

  state_e             state_q;
  logic               ready_q;
  logic               resp_valid_q;
  logic [BITS-1:0]    resp_rdata_q;
  logic               mem_wen_q;
  logic [BITS-1:0]    mem_a_q;
  logic [BITS-1:0]    mem_d_q;
  logic [LAT_W-1:0]   lat_cnt_q;
  logic               wen_q;
  logic [BITS-1:0]    addr_q;
  logic [BITS-1:0]    wdata_q;

  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic               arr_hit;
  logic [BITS-1:0]    arr_data;
  logic               fill_last;
  logic               arr_we;
  logic [BITS-1:0]    arr_wdata;

  assign idx = addr_q[IDX_W+1:2];
  assign tag = addr_q[BITS-1:IDX_W+2];

  // Last FILL cycle: mem_q has been presented for MISS_LAT cycles and is captured on this edge.
  assign fill_last = (state_q == ST_FILL) && (lat_cnt_q == LAT_W'(MISS_LAT - 1));

  // Fills allocate; writes only refresh a line that already holds this address.
  assign arr_we    = fill_last || ((state_q == ST_WRITE) && arr_hit);
  assign arr_wdata = (state_q == ST_FILL) ? mem_q : wdata_q;

  dm_cache_array #(
    .BITS  (BITS),
    .LINES (LINES)
  ) u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx_i  (idx),
    .rd_tag_i  (tag),
    .hit_o     (arr_hit),
    .rd_data_o (arr_data),
    .we_i      (arr_we),
    .wr_idx_i  (idx),
    .wr_tag_i  (tag),
    .wr_data_i (arr_wdata)
  );

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      mem_wen_q    <= 1'b0;
      mem_a_q      <= '0;
      mem_d_q      <= '0;
      lat_cnt_q    <= '0;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (core.req_valid) begin
            wen_q   <= core.req_wen;
            // Byte offset dropped here so mem_a is always word-aligned.
            addr_q  <= core.req_addr & ~BITS'(3);
            wdata_q <= core.req_wdata;
            ready_q <= 1'b0;
            state_q <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (wen_q) begin
            mem_wen_q <= 1'b1;
            mem_a_q   <= addr_q;
            mem_d_q   <= wdata_q;
            state_q   <= ST_WRITE;
          end else if (arr_hit) begin
            resp_valid_q <= 1'b1;
            resp_rdata_q <= arr_data;
            ready_q      <= 1'b1;
            state_q      <= ST_IDLE;
          end else begin
            mem_a_q   <= addr_q;
            lat_cnt_q <= '0;
            state_q   <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (fill_last) begin
            resp_valid_q <= 1'b1;
            resp_rdata_q <= mem_q;
            ready_q      <= 1'b1;
            state_q      <= ST_IDLE;
          end else begin
            lat_cnt_q <= lat_cnt_q + LAT_W'(1);
          end
        end
        ST_WRITE: begin
          mem_wen_q    <= 1'b0;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= '0;
          ready_q      <= 1'b1;
          state_q      <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign core.req_ready  = ready_q;
  assign core.resp_valid = resp_valid_q;
  assign core.resp_rdata = resp_rdata_q;
  assign mem_wen         = mem_wen_q;
  assign mem_a           = mem_a_q;
  assign mem_d           = mem_d_q;

`ifdef DM_CACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // Read hit/miss is decided in LOOKUP; counters saturate instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if ((state_q == ST_LOOKUP) && !wen_q) begin
      if (arr_hit) begin
        if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
      end else begin
        if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dm_cache.sv
// tb_dm_cache: self-checking bench for dm_cache with a word memory at 0x1000 (32 words).
// Latency: n/a.
// Backpressure: requests are held until req_ready; a new request may be offered while the cache is busy.
module tb_dm_cache;

  localparam int BITS = 32;
  localparam int ML   = 2;
  localparam int NCYC = 8192;

  logic        clk;
  logic        rst_n;
  logic        mem_wen;
  logic [31:0] mem_a;
  logic [31:0] mem_d;
  logic [31:0] mem_q;
`ifdef DM_CACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  dm_cache_if #(.BITS(BITS)) core_if ();

  dm_cache #(.BITS(BITS), .LINES(8), .MISS_LAT(ML)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .core     (core_if),
    .mem_wen  (mem_wen),
    .mem_a    (mem_a),
    .mem_d    (mem_d),
    .mem_q    (mem_q)
`ifdef DM_CACHE_STATS_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment memory: combinational read, write on posedge, X outside the mapped window.
  logic [31:0] tmem [32];
  always_comb begin
    if (mem_a >= 32'h1000 && mem_a < 32'h1080) mem_q = tmem[mem_a[6:2]];
    else                                        mem_q = 'x;
  end
  always @(posedge clk) begin
    if (mem_wen === 1'b1 && mem_a >= 32'h1000 && mem_a < 32'h1080) tmem[mem_a[6:2]] <= mem_d;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle expectations, indexed by cycle number.
  bit          e_rv    [NCYC];
  bit          e_rdy_lo[NCYC];
  bit          e_wen   [NCYC];
  bit          e_a_vld [NCYC];
  bit          e_rst   [NCYC];
  logic [31:0] e_rd    [NCYC];
  logic [31:0] e_a     [NCYC];
  logic [31:0] e_d     [NCYC];

  // Reference model: golden memory plus which address each line holds.
  logic [31:0] ref_mem [32];
  bit          mv [8];
  logic [31:0] mt [8];
  int          m_hits, m_misses;

  int          n_err, n_chk;
  int          n_resp, n_exp, last_resp_cyc;
  logic [31:0] last_rdata;
  bit          chk_en;
  logic [31:0] h_a, h_d;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h expected=%h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  function automatic bit in_rng(input int i);
    return (i >= 0) && (i < NCYC);
  endfunction

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en && in_rng(cyc)) begin
      if (e_rst[cyc]) begin
        h_a = 32'h0;
        h_d = 32'h0;
      end
      if (e_a_vld[cyc]) h_a = e_a[cyc];
      if (e_wen[cyc]) begin
        h_a = e_a[cyc];
        h_d = e_d[cyc];
      end
      chk("req_ready", {31'b0, core_if.req_ready}, {31'b0, !e_rdy_lo[cyc]});
      chk("resp_valid", {31'b0, core_if.resp_valid}, {31'b0, e_rv[cyc]});
      chk("mem_wen", {31'b0, mem_wen}, {31'b0, e_wen[cyc]});
      chk("mem_a", mem_a, h_a);
      chk("mem_d", mem_d, h_d);
      if (e_rv[cyc]) begin
        chk("resp_rdata", core_if.resp_rdata, e_rd[cyc]);
`ifdef DM_CACHE_STATS_EN
        chk("hit_cnt", hit_cnt, m_hits);
        chk("miss_cnt", miss_cnt, m_misses);
`endif
      end
      if (core_if.resp_valid === 1'b1) begin
        n_resp++;
        last_resp_cyc = cyc;
        last_rdata    = core_if.resp_rdata;
      end
    end
  end

  // Predict one transaction accepted on the edge that starts cycle p0.
  task automatic model_accept(input bit wen, input logic [31:0] addr, input logic [31:0] wd,
                              input int p0, output int lat, output logic [31:0] rd);
    logic [31:0] wa;
    int          w, idx;
    logic [31:0] tag;
    wa  = addr & 32'hFFFF_FFFC;
    w   = int'((wa - 32'h1000) / 4);
    idx = int'((wa / 4) % 8);
    tag = wa / 32;
    if (wen) begin
      lat = 3;
      rd  = 32'h0;
      ref_mem[w] = wd;
      if (in_rng(p0 + 1)) begin
        e_wen[p0+1] = 1'b1;
        e_a[p0+1]   = wa;
        e_d[p0+1]   = wd;
      end
    end else begin
      rd = ref_mem[w];
      if (mv[idx] && mt[idx] == tag) begin
        lat = 2;
        m_hits++;
      end else begin
        lat = 2 + ML;
        m_misses++;
        mv[idx] = 1'b1;
        mt[idx] = tag;
        for (int k = 1; k <= ML; k++) begin
          if (in_rng(p0 + k)) begin
            e_a_vld[p0+k] = 1'b1;
            e_a[p0+k]     = wa;
          end
        end
      end
    end
    for (int k = 0; k <= lat - 2; k++) if (in_rng(p0 + k)) e_rdy_lo[p0+k] = 1'b1;
    if (in_rng(p0 + lat - 1)) begin
      e_rv[p0+lat-1] = 1'b1;
      e_rd[p0+lat-1] = rd;
    end
  endtask

  // Called at negedge+1; returns at negedge+1 of the LOOKUP cycle with req_valid dropped.
  task automatic issue(input bit wen, input logic [31:0] addr, input logic [31:0] wd,
                       output int p0, output int lat, output logic [31:0] rd);
    int n;
    core_if.req_valid = 1'b1;
    core_if.req_wen   = wen;
    core_if.req_addr  = addr;
    core_if.req_wdata = wd;
    n = 0;
    while (core_if.req_ready !== 1'b1 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      n_chk++;
      n_err++;
      $display("FAIL accept_timeout: actual=no_ready expected=ready cyc=%0d", cyc);
      core_if.req_valid = 1'b0;
      p0  = -1;
      lat = 0;
      rd  = 32'h0;
      return;
    end
    p0 = cyc + 1;
    n_exp++;
    model_accept(wen, addr, wd, p0, lat, rd);
    @(negedge clk); #1;
    core_if.req_valid = 1'b0;
  endtask

  // Directed transaction with hand-computed latency and data.
  task automatic run(input bit wen, input logic [31:0] addr, input logic [31:0] wd,
                     input int x_lat, input logic [31:0] x_rd);
    int          p0, lat, prev, k;
    logic [31:0] rd;
    prev = n_resp;
    issue(wen, addr, wd, p0, lat, rd);
    chk("model_lat", lat, x_lat);
    chk("model_rdata", rd, x_rd);
    k = 0;
    while (n_resp == prev && k < 20) begin
      @(negedge clk); #1;
      k++;
    end
    if (n_resp == prev) begin
      n_chk++;
      n_err++;
      $display("FAIL resp_timeout: actual=none expected=resp addr=%h", addr);
    end else begin
      chk("dut_lat", last_resp_cyc - p0 + 1, x_lat);
      chk("dut_rdata", last_rdata, x_rd);
    end
  endtask

  task automatic do_reset(input int n);
    int c;
    c = cyc;
    rst_n = 1'b1;
    for (int k = c + 1; k <= c + n + 10; k++) begin
      if (in_rng(k)) begin
        e_rv[k]     = 1'b0;
        e_rdy_lo[k] = 1'b0;
        e_wen[k]    = 1'b0;
        e_a_vld[k]  = 1'b0;
        e_rst[k]    = (k <= c + n);
      end
    end
    for (int i = 0; i < 8; i++) mv[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
    repeat (n) begin
      @(negedge clk); #1;
    end
    rst_n = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int          p0, lat, prev, k;
    logic [31:0] rd;
    bit          w;
    logic [31:0] a;

    for (int i = 0; i < 32; i++) begin
      tmem[i]    = 32'h0;
      ref_mem[i] = 32'h0;
    end
    for (int i = 0; i < 8; i++) begin
      mv[i] = 1'b0;
      mt[i] = 32'h0;
    end
    h_a = 32'h0;
    h_d = 32'h0;
    core_if.req_valid = 1'b0;
    core_if.req_wen   = 1'b0;
    core_if.req_addr  = 32'h0;
    core_if.req_wdata = 32'h0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    rst_n  = 1'b0;
    chk_en = 1'b1;

    chk("rst_req_ready", {31'b0, core_if.req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, core_if.resp_valid}, 32'd0);
    chk("rst_resp_rdata", core_if.resp_rdata, 32'h0);
    chk("rst_mem_wen", {31'b0, mem_wen}, 32'd0);
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_d", mem_d, 32'h0);
`ifdef DM_CACHE_STATS_EN
    chk("rst_hit_cnt", hit_cnt, 32'd0);
    chk("rst_miss_cnt", miss_cnt, 32'd0);
`endif

    run(1'b0, 32'h1000, 32'h0,        4, 32'h0);
    run(1'b1, 32'h1004, 32'hDEADBEEF, 3, 32'h0);
    run(1'b0, 32'h1004, 32'h0,        4, 32'hDEADBEEF);
    run(1'b0, 32'h1004, 32'h0,        2, 32'hDEADBEEF);
    run(1'b0, 32'h1008, 32'h0,        4, 32'h0);
    run(1'b1, 32'h1008, 32'h12345678, 3, 32'h0);
    run(1'b0, 32'h1008, 32'h0,        2, 32'h12345678);

    // Reset during the first FILL cycle of a miss: the response must never appear.
    prev = n_resp;
    issue(1'b0, 32'h1040, 32'h0, p0, lat, rd);
    @(negedge clk); #1;
    do_reset(2);
    n_exp--;
    repeat (6) begin
      @(negedge clk); #1;
    end
    chk("abort_no_resp", n_resp, prev);

    run(1'b0, 32'h1000, 32'h0, 4, 32'h0);
    run(1'b0, 32'h1020, 32'h0, 4, 32'h0);
    run(1'b0, 32'h1000, 32'h0, 4, 32'h0);
`ifdef DM_CACHE_STATS_EN
    chk("stats_miss3", miss_cnt, 32'd3);
    chk("stats_hit0", hit_cnt, 32'd0);
`endif

    // Back-to-back: second request offered while the first is still in flight.
    issue(1'b0, 32'h1004, 32'h0, p0, lat, rd);
    issue(1'b0, 32'h1004, 32'h0, p0, lat, rd);
    issue(1'b1, 32'h1010, 32'hA5A5_0001, p0, lat, rd);

    for (int t = 0; t < 300; t++) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk); #1;
      end
      w = ($urandom_range(0, 9) < 4);
      a = 32'h1000 + 32'($urandom_range(0, 31) * 4) + 32'($urandom_range(0, 3));
      issue(w, a, $urandom, p0, lat, rd);
    end

    k = 0;
    while (n_resp != n_exp && k < 20) begin
      @(negedge clk); #1;
      k++;
    end
    chk("resp_count", n_resp, n_exp);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
